// File: rtl/apb_dev_pkg.sv
// Shared definitions for the APB device decoder: FSM state encoding,
// the read data returned on failed accesses, and the error type codes.
package apb_dev_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TOUT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Read data returned upstream for unmapped or timed-out accesses.
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_UNMAPPED = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_type_e;

endpackage

// File: rtl/apb_dev_timeout.sv
// Wait-state counter for the ACCESS phase. Counts stalled enable cycles and
// flags expiry once the count reaches TIMEOUT-1.
module apb_dev_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Wait counter: cleared outside ACCESS, holds once terminal count is hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == TERM);

endmodule

// File: rtl/apb_dev_decoder.sv
// APB one-to-many decoder. Routes the upstream transfer to the device picked
// by a 3-bit address field, answers unmapped addresses and stalled devices
// itself with ERR_DATA, and records the first uncleared error.
module apb_dev_decoder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLV    = 4,
    parameter int SEL_LSB    = 12,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // upstream
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [ADDR_WIDTH-1:0]         paddr,
    input  logic [DATA_WIDTH-1:0]         pwdata,
    output logic [DATA_WIDTH-1:0]         prdata,
    output logic                          pready,
    // devices
    output logic [NUM_SLV-1:0]            dev_psel,
    output logic                          dev_penable,
    output logic                          dev_pwrite,
    output logic [ADDR_WIDTH-1:0]         dev_paddr,
    output logic [DATA_WIDTH-1:0]         dev_pwdata,
    input  logic [NUM_SLV*DATA_WIDTH-1:0] dev_prdata,
    input  logic [NUM_SLV-1:0]            dev_pready,
    // status
    output logic                          err_irq,
    output logic [1:0]                    err_type,
    output logic [ADDR_WIDTH-1:0]         err_addr,
    output logic [7:0]                    err_cnt,
    input  logic                          err_clr
);

    import apb_dev_pkg::*;

    localparam logic [3:0] NUM_SLV_W = 4'(NUM_SLV);

    state_e                state, state_n;
    logic [2:0]            idx;
    logic                  mapped;
    logic [DATA_WIDTH-1:0] rd_slice;
    logic                  sel_ready;
    logic                  cnt_en;
    logic                  cnt_clr;
    logic                  expired;
    logic                  err_evt;
    err_type_e             err_code;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign idx    = paddr[SEL_LSB+2:SEL_LSB];
    assign mapped = ({1'b0, idx} < NUM_SLV_W);

    // Pick the addressed device's read data and ready.
    always_comb begin
        rd_slice  = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == 3'(i)) begin
                rd_slice  = dev_prdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_ready = dev_pready[i];
            end
        end
    end

    // One-hot device select, suppressed during TOUT and while in reset.
    always_comb begin
        dev_psel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            dev_psel[i] = rst_n && psel && mapped && (state != ST_TOUT) && (idx == 3'(i));
        end
    end

    assign dev_penable = penable && (state == ST_ACCESS);
    assign dev_pwrite  = pwrite;
    assign dev_paddr   = paddr;
    assign dev_pwdata  = pwdata;

    assign cnt_clr = (state != ST_ACCESS);

    apb_dev_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clr),
        .enable  (cnt_en),
        .expired (expired)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, upstream response and error event.
    always_comb begin
        state_n  = state;
        pready   = 1'b0;
        prdata   = '0;
        cnt_en   = 1'b0;
        err_evt  = 1'b0;
        err_code = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (psel) begin
                    state_n = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    // Upstream abandoned the transfer; nothing is logged.
                    state_n = ST_IDLE;
                end else if (penable) begin
                    if (!mapped) begin
                        pready   = 1'b1;
                        prdata   = DATA_WIDTH'(ERR_DATA);
                        err_evt  = 1'b1;
                        err_code = ERR_UNMAPPED;
                        state_n  = ST_DONE;
                    end else if (sel_ready) begin
                        pready  = 1'b1;
                        prdata  = rd_slice;
                        state_n = ST_DONE;
                    end else if (expired) begin
                        state_n = ST_TOUT;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_TOUT: begin
                pready   = 1'b1;
                prdata   = DATA_WIDTH'(ERR_DATA);
                err_evt  = 1'b1;
                err_code = ERR_TIMEOUT;
                state_n  = ST_DONE;
            end
            ST_DONE: begin
                // A fresh setup phase right after completion skips IDLE.
                if (psel && !penable) begin
                    state_n = ST_ACCESS;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Error log: first error keeps its fields; a new error beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_irq  <= 1'b0;
            err_type <= 2'b00;
            err_addr <= '0;
            err_cnt  <= 8'h00;
        end else if (err_evt) begin
            err_irq <= 1'b1;
            err_cnt <= sat_inc8(err_cnt);
            if (!err_irq || err_clr) begin
                err_type <= err_code;
                err_addr <= paddr;
            end
        end else if (err_clr) begin
            err_irq  <= 1'b0;
            err_type <= 2'b00;
            err_addr <= '0;
        end
    end

endmodule

// File: doc/apb_dev_decoder.md
APB_DEV_DECODER -- requirements
Module: apb_dev_decoder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter NUM_SLV, default 4, number of attached APB devices (1..8).
REQ-004 SHALL have parameter SEL_LSB, default 12, lowest paddr bit of the 3-bit device index field.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum wait cycles in ACCESS before abort.
REQ-006 SHALL use one clock and an asynchronous active-low reset: clk  input  1  system clock; rst_n  input  1  asynchronous reset, active low.
REQ-007 Upstream ports SHALL be:
- psel  input  1  upstream select
- penable  input  1  upstream enable
- pwrite  input  1  write when 1
- paddr  input  ADDR_WIDTH  address
- pwdata  input  DATA_WIDTH  write data
- prdata  output  DATA_WIDTH  read data
- pready  output  1  transfer complete
REQ-008 Device-side ports SHALL be:
- dev_psel  output  NUM_SLV  one-hot device select
- dev_penable  output  1  enable
- dev_pwrite  output  1  direction
- dev_paddr  output  ADDR_WIDTH  address
- dev_pwdata  output  DATA_WIDTH  write data
- dev_prdata  input  NUM_SLV*DATA_WIDTH  packed read data, device i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- dev_pready  input  NUM_SLV  per-device ready
REQ-009 Status ports SHALL be:
- err_irq  output  1  level error flag
- err_type  output  2  01 = unmapped, 10 = timeout
- err_addr  output  ADDR_WIDTH  address of first uncleared error
- err_cnt  output  8  saturating error count
- err_clr  input  1  one-cycle clear pulse

Function
REQ-010 idx = paddr[SEL_LSB+2:SEL_LSB]; mapped = (idx < NUM_SLV).
REQ-011 dev_psel[idx] = psel & mapped & (state != TOUT); all other bits 0; combinational, zero added latency.
REQ-012 dev_penable = penable & (state == ACCESS); dev_pwrite/dev_paddr/dev_pwdata pass through unregistered.
REQ-013 FSM states: IDLE, ACCESS, TOUT, DONE.
REQ-014 IDLE: psel=1 -> ACCESS; wait counter cleared to 0.
REQ-015 ACCESS, penable=1, unmapped: pready=1, prdata=32'hDEAD_BEEF in the same cycle; error logged; -> DONE.
REQ-016 ACCESS, penable=1, mapped, dev_pready[idx]=1: pready=1, prdata=dev_prdata slice idx; -> DONE.
REQ-017 ACCESS, penable=1, mapped, dev_pready[idx]=0: counter increments; at counter == TIMEOUT-1 -> TOUT.
REQ-018 TOUT lasts one cycle: dev_psel all 0, pready=1, prdata=32'hDEAD_BEEF, error logged; -> DONE.
REQ-019 DONE: pready=0; psel=1 & penable=0 -> ACCESS (back-to-back setup); otherwise -> IDLE.
REQ-020 pready SHALL be 0 in IDLE and DONE; prdata SHALL be 0 whenever pready=0.
REQ-021 Error logging:
- err_irq set to 1.
- err_cnt increments, saturating at 8'hFF.
- err_type and err_addr loaded only if err_irq was 0 (first error kept).
REQ-022 err_clr=1 clears err_irq, err_type and err_addr next cycle; err_cnt is not cleared by err_clr.
REQ-023 Simultaneous err_clr and new error: the new error wins; fields reload from the new error and err_cnt increments.
REQ-024 psel dropping mid-ACCESS (upstream abort): -> IDLE next cycle; no error logged.

Reset
REQ-025 While rst_n=0, asynchronously: state=IDLE, wait counter=0, err_irq=0, err_type=0, err_addr=0, err_cnt=0; pready=0, prdata=0, dev_psel=0, dev_penable=0.
REQ-026 Reset mid-transfer SHALL abandon the transfer with no error logged; normal operation resumes on the first clock edge after rst_n rises.

Structure
REQ-027 Shared package apb_dev_pkg SHALL hold the FSM state encoding, the ERR_DATA constant 32'hDEAD_BEEF, and the err_type codes.
REQ-028 The wait counter and its terminal-count compare SHALL be one sub-module, apb_dev_timeout (inputs: clear, enable; output: expired).

Verification
REQ-029 Mapped read: paddr=0x0000_1004, dev_pready[1] high on the first enable cycle, dev_prdata slice 1 = 0x1234_5678 -> dev_psel=4'b0010, pready=1 in the first enable cycle, prdata=0x1234_5678, err_irq=0.
REQ-030 Unmapped write: paddr=0x0000_6000 (idx=6) -> dev_psel=0, pready=1 in the first enable cycle, err_irq=1, err_type=01, err_addr=0x0000_6000, err_cnt=1.
REQ-031 Timeout: device 2 holds dev_pready low with TIMEOUT=255 -> TOUT reached after 255 enable cycles, pready=1, prdata=0xDEAD_BEEF, err_type=10.
REQ-032 Second error before clear: unmapped access at 0x7000, then timeout -> err_addr stays 0x7000, err_cnt=2; then err_clr -> err_irq=0, err_cnt still 2.
REQ-033 Clear collision: err_clr asserted in the same cycle as an unmapped access at 0x5000 -> err_irq=1, err_addr=0x5000.
REQ-034 Reset mid-ACCESS: rst_n low for 2 cycles while a slow device is stalled -> all outputs 0 asynchronously, err_cnt=0; the next transfer completes normally.
